// File: rtl/mac_chunk_seq.sv
// mac_chunk_seq: streams operand chunks into an external dot-product MAC and
// accumulates its results into a wider signed sum with a held output.
`timescale 1ns/1ps

module mac_chunk_seq #(
    parameter int unsigned bw      = 8,
    parameter int unsigned pr      = 8,
    parameter int unsigned bw_psum = 2*bw+6,
    parameter int unsigned bw_acc  = bw_psum+4,
    parameter int unsigned len_bw  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [len_bw-1:0]   len,
    output logic                busy,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [pr*bw-1:0]    in_a,
    input  logic [pr*bw-1:0]    in_b,
    output logic [pr*bw-1:0]    mac_a,
    output logic [pr*bw-1:0]    mac_b,
    input  logic [bw_psum-1:0]  mac_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [bw_acc-1:0]   out_psum,
    output logic                done
);

    localparam int unsigned EXT_W = bw_acc - bw_psum;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        LAST = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t              state_q;
    logic [len_bw-1:0]   remaining_q;
    logic                s1_valid_q;
    logic                first_q;
    logic [bw_acc-1:0]   acc_q;
    logic [pr*bw-1:0]    mac_a_q;
    logic [pr*bw-1:0]    mac_b_q;
    logic                out_valid_q;
    logic [bw_acc-1:0]   out_psum_q;
    logic                done_q;
    logic                busy_q;
    logic                in_ready_q;

    logic [bw_acc-1:0]   mac_sext;
    logic [bw_acc-1:0]   acc_d;
    logic                in_hs;

    // Sign-extend the MAC result and form the next running sum.
    always_comb begin
        mac_sext = {{EXT_W{mac_out[bw_psum-1]}}, mac_out};
        acc_d    = (first_q ? '0 : acc_q) + mac_sext;
        in_hs    = in_valid & in_ready_q;
    end

    // Job sequencing, operand capture, accumulation and output holding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            s1_valid_q  <= 1'b0;
            first_q     <= 1'b0;
            acc_q       <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_psum_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (s1_valid_q) begin
                acc_q   <= acc_d;
                first_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (start && (len != '0)) begin
                        remaining_q <= len;
                        s1_valid_q  <= 1'b0;
                        first_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        in_ready_q  <= 1'b1;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        mac_a_q     <= in_a;
                        mac_b_q     <= in_b;
                        s1_valid_q  <= 1'b1;
                        remaining_q <= remaining_q - len_bw'(1);
                        if (remaining_q == len_bw'(1)) begin
                            in_ready_q <= 1'b0;
                            state_q    <= LAST;
                        end
                    end else begin
                        s1_valid_q <= 1'b0;
                    end
                end
                LAST: begin
                    // The final chunk's product is folded in directly here.
                    out_psum_q  <= acc_d;
                    out_valid_q <= 1'b1;
                    s1_valid_q  <= 1'b0;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign in_ready  = in_ready_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign out_valid = out_valid_q;
    assign out_psum  = out_psum_q;
    assign done      = done_q;

endmodule

// File: tb/tb_mac_chunk_seq.sv
// tb_mac_chunk_seq: directed scenarios for mac_chunk_seq with a behavioural
// 8-lane signed dot-product standing in for the external MAC.
`timescale 1ns/1ps

module tb_mac_chunk_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   len;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_a;
    logic [63:0]  in_b;
    logic [63:0]  mac_a;
    logic [63:0]  mac_b;
    logic [21:0]  mac_out;
    logic         out_valid;
    logic         out_ready;
    logic [25:0]  out_psum;
    logic         done;

    int checks = 0;
    int passed = 0;

    mac_chunk_seq dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mac_a     (mac_a),
        .mac_b     (mac_b),
        .mac_out   (mac_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_psum  (out_psum),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Combinational signed dot product of the registered operands.
    always_comb begin
        int s;
        s = 0;
        for (int i = 0; i < 8; i++) begin
            s = s + $signed(mac_a[8*i +: 8]) * $signed(mac_b[8*i +: 8]);
        end
        mac_out = 22'(s);
    end

    function automatic logic [63:0] rep(input logic [7:0] v);
        return {8{v}};
    endfunction

    task automatic start_job(input logic [3:0] n);
        start = 1'b1;
        len   = n;
        @(negedge clk);
        start = 1'b0;
        len   = 4'd0;
    endtask

    // gaps: idle cycles before chunk k held in nibble k.
    task automatic feed(input int n, input logic [7:0] a, input logic [7:0] b,
                        input int unsigned gaps, output bit ready_drop);
        ready_drop = 1'b0;
        for (int k = 0; k < n; k++) begin
            for (int g = 0; g < int'((gaps >> (4*k)) & 32'hF); g++) begin
                in_valid = 1'b0;
                if (in_ready !== 1'b1) ready_drop = 1'b1;
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_a     = rep(a);
            in_b     = rep(b);
            if (in_ready !== 1'b1) ready_drop = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_a     = '0;
        in_b     = '0;
    endtask

    task automatic wait_out(output int cycles);
        cycles = 0;
        while (out_valid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000) begin
            $display("FAIL reset_flags: got %b expected 0000", {busy, in_ready, out_valid, done});
        end else passed++;
        checks++;
        if (mac_a !== 64'd0 || mac_b !== 64'd0 || out_psum !== 26'd0) begin
            $display("FAIL reset_data: mac_a=%h mac_b=%h out_psum=%h expected all 0", mac_a, mac_b, out_psum);
        end else passed++;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        bit drop;
        int cyc;
        start_job(4'd1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL single_run_entry: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end else passed++;
        feed(1, 8'd1, 8'd2, 0, drop);
        checks++;
        if (in_ready !== 1'b0 || mac_a !== rep(8'd1) || mac_b !== rep(8'd2) || out_valid !== 1'b0) begin
            $display("FAIL single_last: in_ready=%b mac_a=%h mac_b=%h out_valid=%b", in_ready, mac_a, mac_b, out_valid);
        end else passed++;
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc !== 1) begin
            $display("FAIL single_latency: out_valid=%b after %0d extra cycles, expected 1 after 1", out_valid, cyc);
        end else passed++;
        checks++;
        if (out_psum !== 26'd16) begin
            $display("FAIL single_sum: got %0d expected 16", $signed(out_psum));
        end else passed++;
        release_out();
        checks++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL single_done: done=%b out_valid=%b busy=%b expected 1 0 0", done, out_valid, busy);
        end else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            $display("FAIL single_done_pulse: done=%b expected 0", done);
        end else passed++;
    endtask

    task automatic test_back_to_back;
        bit drop;
        int cyc;
        start_job(4'd4);
        feed(4, 8'd1, 8'd2, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || cyc !== 1 || drop !== 1'b0) begin
            $display("FAIL b2b_timing: out_valid=%b cyc=%0d ready_drop=%b expected 1 1 0", out_valid, cyc, drop);
        end else passed++;
        checks++;
        if (out_psum !== 26'd64) begin
            $display("FAIL b2b_sum: got %0d expected 64", $signed(out_psum));
        end else passed++;
        release_out();
        @(negedge clk);
    endtask

    task automatic test_gaps;
        bit drop;
        int cyc;
        int unsigned gaps;
        gaps = 0;
        for (int i = 0; i < 3; i++) gaps = gaps + (32'd1 << (4 * $urandom_range(1, 3)));
        start_job(4'd4);
        feed(4, 8'd1, 8'd2, gaps, drop);
        checks++;
        if (drop !== 1'b0) begin
            $display("FAIL gaps_in_ready: ready_drop=%b expected 0", drop);
        end else passed++;
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'd64) begin
            $display("FAIL gaps_sum: out_valid=%b got %0d expected 1 and 64", out_valid, $signed(out_psum));
        end else passed++;
        release_out();
        @(negedge clk);
    endtask

    task automatic test_signed;
        bit drop;
        int cyc;
        start_job(4'd15);
        feed(15, 8'h80, 8'h7F, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'(-1950720)) begin
            $display("FAIL signed_neg: out_valid=%b got %0d expected -1950720", out_valid, $signed(out_psum));
        end else passed++;
        release_out();
        @(negedge clk);
        start_job(4'd15);
        feed(15, 8'h80, 8'h80, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'd1966080) begin
            $display("FAIL signed_pos: out_valid=%b got %0d expected 1966080", out_valid, $signed(out_psum));
        end else passed++;
        release_out();
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        bit drop;
        bit bad;
        int cyc;
        start_job(4'd2);
        feed(2, 8'd3, 8'hFF, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'(-48)) begin
            $display("FAIL bp_sum: out_valid=%b got %0d expected -48", out_valid, $signed(out_psum));
        end else passed++;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (out_psum !== 26'(-48) || out_valid !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) bad = 1'b1;
            start = (i == 2);
            len   = (i == 2) ? 4'd3 : 4'd0;
            @(negedge clk);
        end
        start = 1'b0;
        len   = 4'd0;
        checks++;
        if (bad !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1) begin
            $display("FAIL bp_hold: unstable=%b out_valid=%b busy=%b expected 0 1 1", bad, out_valid, busy);
        end else passed++;
        release_out();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            $display("FAIL bp_release: done=%b busy=%b expected 1 0", done, busy);
        end else passed++;
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            $display("FAIL bp_after: done=%b busy=%b in_ready=%b expected 0 0 0", done, busy, in_ready);
        end else passed++;
    endtask

    task automatic test_len_zero;
        bit bad;
        start_job(4'd0);
        bad = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (bad !== 1'b0) begin
            $display("FAIL len_zero: busy/out_valid/in_ready rose, got flag %b expected 0", bad);
        end else passed++;
    endtask

    task automatic test_start_in_done;
        bit drop;
        int cyc;
        start_job(4'd1);
        feed(1, 8'd2, 8'd2, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'd32) begin
            $display("FAIL sid_first: out_valid=%b got %0d expected 32", out_valid, $signed(out_psum));
        end else passed++;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (done !== 1'b1) begin
            $display("FAIL sid_done: done=%b expected 1", done);
        end else passed++;
        start_job(4'd2);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            $display("FAIL sid_accept: busy=%b in_ready=%b expected 1 1", busy, in_ready);
        end else passed++;
        feed(2, 8'd1, 8'd1, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'd16) begin
            $display("FAIL sid_second: out_valid=%b got %0d expected 16", out_valid, $signed(out_psum));
        end else passed++;
        release_out();
        @(negedge clk);
    endtask

    task automatic test_abort;
        bit drop;
        int cyc;
        start_job(4'd4);
        feed(2, 8'd5, 8'd5, 0, drop);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, in_ready, out_valid, done} !== 4'b0000 || mac_a !== 64'd0 || mac_b !== 64'd0 || out_psum !== 26'd0) begin
            $display("FAIL abort_clear: flags=%b mac_a=%h mac_b=%h out_psum=%h expected all 0",
                     {busy, in_ready, out_valid, done}, mac_a, mac_b, out_psum);
        end else passed++;
        reset = 1'b0;
        start_job(4'd1);
        feed(1, 8'd1, 8'd3, 0, drop);
        wait_out(cyc);
        checks++;
        if (out_valid !== 1'b1 || out_psum !== 26'd24) begin
            $display("FAIL abort_fresh: out_valid=%b got %0d expected 24", out_valid, $signed(out_psum));
        end else passed++;
        release_out();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        len       = 4'd0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_gaps();
        test_signed();
        test_backpressure();
        test_len_zero();
        test_start_in_done();
        test_abort();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
